// File: rtl/switch_pattern_seq.sv
// Photonic switch pattern sequencer.
// Plays a latched bit pattern (LSB first) onto sw_out, one bit per rising edge
// of the 8 MHz enable, for a programmed number of passes or until aborted.
//
// state | meaning
// IDLE  | waiting for start; sw_out low
// ARMED | pattern latched, waiting for the first strobe
// RUN   | driving pattern bits, one per strobe
module switch_pattern_seq #(
  parameter int PAT_W = 32,
  parameter int REP_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_8MHz,
  input  logic                      start,
  input  logic                      abort,
  input  logic [PAT_W-1:0]          pattern_in,
  input  logic [$clog2(PAT_W):0]    len_in,
  input  logic [REP_W-1:0]          repeat_in,
  output logic                      sw_out,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(PAT_W)-1:0]  bit_idx,
  output logic [REP_W-1:0]          rep_cnt
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam int LEN_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t             state;
  logic               en_d;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [REP_W-1:0]   rep_q;

  logic               strobe;
  logic               len_ok;
  logic               last_bit;
  logic               more_passes;
  logic [IDX_W-1:0]   idx_nxt;
  logic [REP_W-1:0]   rep_nxt;

  assign strobe      = en_8MHz & ~en_d;
  assign len_ok      = (len_in != '0) && (len_in <= LEN_W'(PAT_W));
  assign last_bit    = ({1'b0, bit_idx} == (len_q - LEN_W'(1)));
  assign idx_nxt     = bit_idx + IDX_W'(1);
  assign rep_nxt     = rep_cnt + REP_W'(1);
  assign more_passes = (rep_q == '0) || (rep_nxt < rep_q);
  assign busy        = (state != IDLE);

  // Enable edge detector; held high in reset so a level held across reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) en_d <= 1'b1;
    else       en_d <= en_8MHz;
  end

  // Sequencer FSM with registered switch drive and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sw_out  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bit_idx <= '0;
      rep_cnt <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        // bit_idx and rep_cnt are kept so software can see how far it got.
        state  <= IDLE;
        sw_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sw_out <= 1'b0;
            if (start) begin
              if (len_ok) begin
                pat_q   <= pattern_in;
                len_q   <= len_in;
                rep_q   <= repeat_in;
                bit_idx <= '0;
                rep_cnt <= '0;
                state   <= ARMED;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ARMED: begin
            if (strobe) begin
              sw_out  <= pat_q[0];
              bit_idx <= '0;
              state   <= RUN;
            end
          end
          RUN: begin
            if (strobe) begin
              if (!last_bit) begin
                bit_idx <= idx_nxt;
                sw_out  <= pat_q[idx_nxt];
              end else begin
                rep_cnt <= rep_nxt;
                if (more_passes) begin
                  bit_idx <= '0;
                  sw_out  <= pat_q[0];
                end else begin
                  sw_out <= 1'b0;
                  done   <= 1'b1;
                  state  <= IDLE;
                end
              end
            end
          end
          default: begin
            state  <= IDLE;
            sw_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_pattern_seq.sv
// Directed testbench for switch_pattern_seq.
`timescale 1ns/100ps
module tb_switch_pattern_seq;

  localparam int PAT_W = 32;
  localparam int REP_W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_8MHz;
  logic        start;
  logic        abort;
  logic [31:0] pattern_in;
  logic [5:0]  len_in;
  logic [7:0]  repeat_in;
  logic        sw_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  bit_idx;
  logic [7:0]  rep_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int done_base;
  logic [31:0] pat;

  switch_pattern_seq #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_8MHz    (en_8MHz),
    .start      (start),
    .abort      (abort),
    .pattern_in (pattern_in),
    .len_in     (len_in),
    .repeat_in  (repeat_in),
    .sw_out     (sw_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bit_idx    (bit_idx),
    .rep_cnt    (rep_cnt)
  );

  // 200 MHz clock.
  always #2.5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pat(input logic [31:0] p, input logic [5:0] l, input logic [7:0] r);
    pattern_in = p;
    len_in     = l;
    repeat_in  = r;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // One full 25-clk strobe period: en high for 3 clk, low for 22.
  task automatic bit_period(input string tag, input logic b, input logic [4:0] idx);
    en_8MHz = 1'b1;
    tick();
    check({tag, "_sw"}, 32'(sw_out), 32'(b));
    check({tag, "_idx"}, 32'(bit_idx), 32'(idx));
    tick();
    tick();
    en_8MHz = 1'b0;
    repeat (21) tick();
    check({tag, "_hold"}, 32'(sw_out), 32'(b));
    tick();
  endtask

  task automatic fast_strobe();
    en_8MHz = 1'b1;
    tick();
    en_8MHz = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; en_8MHz = 1'b0; start = 1'b0; abort = 1'b0;
    pattern_in = '0; len_in = '0; repeat_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_sw",   32'(sw_out),  32'd0);
    check("rst_busy", 32'(busy),    32'd0);
    check("rst_done", 32'(done),    32'd0);
    check("rst_err",  32'(err),     32'd0);
    check("rst_idx",  32'(bit_idx), 32'd0);
    check("rst_rep",  32'(rep_cnt), 32'd0);

    // 0xA5, len 8, one pass: 1,0,1,0,0,1,0,1
    pat = 32'hA5;
    start_pat(pat, 6'd8, 8'd1);
    check("a5_busy", 32'(busy),   32'd1);
    check("a5_arm",  32'(sw_out), 32'd0);
    for (int i = 0; i < 8; i++) bit_period($sformatf("a5_b%0d", i), pat[i], 5'(i));
    done_base = done_cnt;
    en_8MHz = 1'b1;
    tick();
    check("a5_done",   32'(done),    32'd1);
    check("a5_sw_end", 32'(sw_out),  32'd0);
    check("a5_idle",   32'(busy),    32'd0);
    check("a5_rep",    32'(rep_cnt), 32'd1);
    tick();
    check("a5_done_off", 32'(done), 32'd0);
    en_8MHz = 1'b0;
    tick();
    check("a5_done_once", 32'(done_cnt - done_base), 32'd1);

    // 0b011, len 3, three passes
    pat = 32'h3;
    start_pat(pat, 6'd3, 8'd3);
    for (int ps = 0; ps < 3; ps++) begin
      for (int b = 0; b < 3; b++) begin
        bit_period($sformatf("p3_%0d_%0d", ps, b), pat[b], 5'(b));
        if (b == 0) check($sformatf("p3_rep%0d", ps), 32'(rep_cnt), 32'(ps));
      end
    end
    en_8MHz = 1'b1;
    tick();
    check("p3_done", 32'(done),    32'd1);
    check("p3_rep",  32'(rep_cnt), 32'd3);
    check("p3_sw",   32'(sw_out),  32'd0);
    en_8MHz = 1'b0;
    tick();

    // Infinite mode, len 2: arming strobe plus 300 strobes in RUN = 150 passes
    start_pat(32'h3, 6'd2, 8'd0);
    repeat (301) fast_strobe();
    check("inf_sw_run", 32'(sw_out),  32'd1);
    check("inf_busy",   32'(busy),    32'd1);
    done_base = done_cnt;
    abort = 1'b1; start = 1'b1; en_8MHz = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_sw",   32'(sw_out),  32'd0);
    check("abort_busy", 32'(busy),    32'd0);
    check("abort_rep",  32'(rep_cnt), 32'd150);
    check("abort_idx",  32'(bit_idx), 32'd0);
    en_8MHz = 1'b0;
    repeat (3) tick();
    check("abort_still_idle", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);

    // len 1 infinite: every strobe is a pass; 257 passes wrap rep_cnt to 1
    start_pat(32'h1, 6'd1, 8'd0);
    repeat (258) fast_strobe();
    check("wrap_rep",  32'(rep_cnt), 32'd1);
    check("wrap_sw",   32'(sw_out),  32'd1);
    check("wrap_idx",  32'(bit_idx), 32'd0);
    check("wrap_busy", 32'(busy),    32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wrap_abort", 32'(sw_out), 32'd0);

    // Rejected lengths
    start_pat(32'hF, 6'd0, 8'd1);
    check("len0_err",  32'(err),  32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    tick();
    check("len0_err_off", 32'(err), 32'd0);
    start_pat(32'hF, 6'd33, 8'd1);
    check("len33_err",  32'(err),  32'd1);
    check("len33_busy", 32'(busy), 32'd0);
    tick();
    check("len33_err_off", 32'(err),  32'd0);
    check("len33_idle",    32'(busy), 32'd0);

    // Maximum length
    start_pat(32'h8000_0001, 6'd32, 8'd1);
    check("len32_busy", 32'(busy), 32'd1);
    check("len32_err",  32'(err),  32'd0);
    repeat (32) fast_strobe();
    check("len32_idx", 32'(bit_idx), 32'd31);
    check("len32_sw",  32'(sw_out),  32'd1);
    done_base = done_cnt;
    fast_strobe();
    check("len32_done", 32'(done_cnt - done_base), 32'd1);
    check("len32_idle", 32'(busy), 32'd0);

    // Start coincident with a strobe, then start while running
    pat = 32'hD;
    pattern_in = pat; len_in = 6'd4; repeat_in = 8'd1;
    start = 1'b1; en_8MHz = 1'b1;
    tick();
    start = 1'b0;
    check("coinc_busy", 32'(busy),   32'd1);
    check("coinc_sw",   32'(sw_out), 32'd0);
    tick();
    tick();
    en_8MHz = 1'b0;
    repeat (21) tick();
    check("coinc_armed", 32'(sw_out), 32'd0);
    tick();
    bit_period("coinc_b0", pat[0], 5'd0);
    pattern_in = 32'h0; len_in = 6'd1; repeat_in = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_err",  32'(err),    32'd0);
    check("ign_busy", 32'(busy),   32'd1);
    check("ign_sw",   32'(sw_out), 32'd1);
    for (int b = 1; b < 4; b++) bit_period($sformatf("ign_b%0d", b), pat[b], 5'(b));
    en_8MHz = 1'b1;
    tick();
    check("ign_done", 32'(done),    32'd1);
    check("ign_rep",  32'(rep_cnt), 32'd1);
    en_8MHz = 1'b0;
    tick();

    // Reset mid-run with the enable held high
    start_pat(32'h1, 6'd2, 8'd0);
    en_8MHz = 1'b1;
    tick();
    check("mid_sw", 32'(sw_out), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_sw",   32'(sw_out),  32'd0);
    check("rst_async_busy", 32'(busy),    32'd0);
    check("rst_async_rep",  32'(rep_cnt), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("rel_busy", 32'(busy), 32'd0);
    start_pat(32'h1, 6'd2, 8'd0);
    repeat (5) tick();
    check("rel_no_strobe_sw",   32'(sw_out), 32'd0);
    check("rel_no_strobe_busy", 32'(busy),   32'd1);
    en_8MHz = 1'b0;
    tick();
    en_8MHz = 1'b1;
    tick();
    check("rel_strobe_sw",  32'(sw_out),  32'd1);
    check("rel_strobe_idx", 32'(bit_idx), 32'd0);
    en_8MHz = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
